// File: rtl/alu_issue_pipe.sv
// ---------------------------------------------------------------------------
// alu_issue_pipe
//   Issue/writeback wrapper around an external 16-bit ALU. Instructions come in
//   over a valid/ready handshake, read their operands from an 8x16 register
//   file (with full forwarding from the EX and WB stages), and are presented
//   to the ALU on registered alu_a/alu_b/alu_op. The ALU's 32-bit result is
//   captured into the WB register, offered on the result handshake, and its
//   low 16 bits are written back to rd when the consumer takes it.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    instruction handshake
//   in_instr[15:0]       [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2,
//                        [3] use_imm, [2:0] imm3
//   alu_a, alu_b, alu_op registered operands/opcode to the ALU
//   alu_out[31:0]        combinational ALU result of alu_a/alu_b/alu_op
//   res_valid/res_ready  result handshake
//   res_data[31:0]       full ALU result, res_rd its destination register
//   dbg_addr, dbg_data   combinational register file read port
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. in_ready depends only on res_valid/res_ready, never on
// in_valid; res_valid, once high, holds with stable res_data/res_rd until the
// transfer happens.
// ---------------------------------------------------------------------------
module alu_issue_pipe #(
    parameter int          NREGS   = 8,
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_rd,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    logic [15:0] rf [NREGS];

    logic        ex_valid;
    logic [2:0]  ex_rd;

    logic        adv;
    logic        accept;
    logic        retire;

    logic [2:0]  f_op;
    logic [2:0]  f_rd;
    logic [2:0]  f_rs1;
    logic [2:0]  f_rs2;
    logic        f_use_imm;
    logic [2:0]  f_imm3;

    logic [15:0] src_a;
    logic [15:0] src_b;

    // The whole pipe moves whenever the WB slot is empty or being drained.
    assign adv      = !res_valid || res_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign retire   = res_valid && res_ready;

    assign f_op      = in_instr[15:13];
    assign f_rd      = in_instr[12:10];
    assign f_rs1     = in_instr[9:7];
    assign f_rs2     = in_instr[6:4];
    assign f_use_imm = in_instr[3];
    assign f_imm3    = in_instr[2:0];

    // Operand sourcing: the younger producer (EX, whose result is on alu_out
    // this very cycle) beats the older one (WB), which beats the register
    // file. A WB result retiring this cycle is picked up from res_data, so the
    // register file never needs a write-through path.
    always_comb begin
        src_a = rf[f_rs1];
        if (ex_valid && ex_rd == f_rs1) begin
            src_a = alu_out[15:0];
        end else if (res_valid && res_rd == f_rs1) begin
            src_a = res_data[15:0];
        end
    end

    always_comb begin
        src_b = rf[f_rs2];
        if (ex_valid && ex_rd == f_rs2) begin
            src_b = alu_out[15:0];
        end else if (res_valid && res_rd == f_rs2) begin
            src_b = res_data[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_rd     <= 3'd0;
            alu_a     <= 16'd0;
            alu_b     <= 16'd0;
            alu_op    <= 3'd0;
            res_valid <= 1'b0;
            res_data  <= 32'd0;
            res_rd    <= 3'd0;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= RST_VAL;
            end
        end else begin
            if (adv) begin
                ex_valid <= accept;
                // With no new instruction the ALU inputs simply hold.
                if (accept) begin
                    alu_a  <= src_a;
                    alu_b  <= f_use_imm ? {13'd0, f_imm3} : src_b;
                    alu_op <= f_op;
                    ex_rd  <= f_rd;
                end
                res_valid <= ex_valid;
                res_data  <= alu_out;
                res_rd    <= ex_rd;
            end
            if (retire) begin
                rf[res_rd] <= res_data[15:0];
            end
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_pipe.sv
module tb_alu_issue_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_rd;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_issue_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  // ALU behaviour: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5..7 zero.
  // Operands are zero-extended to 32 bits before the operation.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] xa;
    logic [31:0] xb;
    xa = {16'd0, a};
    xb = {16'd0, b};
    case (op)
      3'd0:    return xa + xb;
      3'd1:    return xa - xb;
      3'd2:    return xa & xb;
      3'd3:    return xa | xb;
      3'd4:    return xa ^ xb;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op, alu_a, alu_b);

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model and scoreboard ----------------
  // With full forwarding the pipe behaves like sequential execution, so the
  // model executes each instruction against architectural registers at the
  // moment it is accepted and queues {rd, result} in program order.
  localparam int W = 35;
  logic [W-1:0] exp_q[$];
  logic [15:0]  mreg [8];
  logic [31:0]  ret_data_log[$];
  int           ret_cyc_log[$];
  int           n_ret = 0;
  int           total = 0;
  int           bad = 0;
  bit           rand_rdy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic [15:0] ins);
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] r;
    a = mreg[ins[9:7]];
    b = ins[3] ? {13'd0, ins[2:0]} : mreg[ins[6:4]];
    r = alu_ref(ins[15:13], a, b);
    mreg[ins[12:10]] = r[15:0];
    exp_q.push_back({ins[12:10], r});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 16'd0;
    exp_q.delete();
  endtask

  // Compare process: checks every retirement and the ready rule each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!res_valid || res_ready)});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire actual=%h rd=%0d required=none", res_data, res_rd);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("res_data", res_data, e[31:0]);
          chk("res_rd", {29'd0, res_rd}, {29'd0, e[34:32]});
        end
        ret_data_log.push_back(res_data);
        ret_cyc_log.push_back(cyc);
        n_ret++;
      end
    end
  end

  // Random backpressure generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) res_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic ui, input logic [2:0] imm);
    return {op, rd, rs1, rs2, ui, imm};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [15:0] ins);
    int  waited;
    bit  done;
    waited = 0;
    done = 0;
    in_valid = 1'b1;
    in_instr = ins;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_push(ins);
        done = 1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 1000) begin
          total++;
          bad++;
          $display("FAIL issue_timeout actual=stalled required=accept instr=%h", ins);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
    in_instr = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    rand_rdy = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    idle(2);
  endtask

  // Combinational debug read; realigns to posedge+1 afterwards.
  task automatic rf_chk(input logic [2:0] idx, input logic [15:0] exp, input string nm);
    dbg_addr = idx;
    #1;
    chk(nm, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  task automatic rf_chk_model(input string nm);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(nm, {16'd0, dbg_data}, {16'd0, mreg[i]});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  int base;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 16'd0;
    res_ready = 1'b1;
    dbg_addr = 3'd0;
    model_reset();
    #23;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_rd", {29'd0, res_rd}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rf_chk_model("rst_rf");

    // 1: ADD imm chain through EX forwarding.
    base = ret_data_log.size();
    issue(mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 3'd5));
    issue(mk(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 3'd3));
    drain();
    chk("t1_first", ret_data_log[base], 32'd5);
    chk("t1_second", ret_data_log[base+1], 32'd8);
    chk("t1_consecutive", 32'(ret_cyc_log[base+1] - ret_cyc_log[base]), 32'd1);
    rf_chk(3'd2, 16'd8, "t1_rf2");
    idle(1);

    // 2: forwarding into SUB, and subtraction underflow.
    base = ret_data_log.size();
    issue(mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 3'd7));
    issue(mk(3'd1, 3'd3, 3'd1, 3'd1, 1'b0, 3'd0));
    issue(mk(3'd1, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0));
    issue(mk(3'd1, 3'd4, 3'd0, 3'd0, 1'b1, 3'd3));
    drain();
    chk("t2_sub_self", ret_data_log[base+1], 32'd0);
    chk("t2_sub_7_8", ret_data_log[base+2], 32'hFFFF_FFFF);
    chk("t2_sub_0_3", ret_data_log[base+3], 32'hFFFF_FFFD);
    rf_chk(3'd4, 16'hFFFD, "t2_rf4");
    rf_chk(3'd5, 16'hFFFF, "t2_rf5");
    idle(1);

    // 3: backpressure holds everything for 4 cycles.
    base = n_ret;
    res_ready = 1'b0;
    issue(mk(3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 3'd2));
    issue(mk(3'd0, 3'd7, 3'd6, 3'd0, 1'b1, 3'd1));
    in_valid = 1'b1;
    in_instr = mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 3'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t3_res_valid", {31'd0, res_valid}, 32'd1);
      chk("t3_res_data", res_data, 32'd2);
      chk("t3_res_rd", {29'd0, res_rd}, 32'd6);
      chk("t3_alu_a", {16'd0, alu_a}, 32'd2);
      chk("t3_alu_b", {16'd0, alu_b}, 32'd1);
      chk("t3_alu_op", {29'd0, alu_op}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    chk("t3_retire_count", 32'(n_ret - base), 32'd2);
    rf_chk(3'd6, 16'd2, "t3_rf6");
    rf_chk(3'd7, 16'd3, "t3_rf7");
    idle(1);

    // 4: logic ops and an opcode that yields zero.
    issue(mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 3'd6));
    issue(mk(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 3'd5));
    issue(mk(3'd2, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0));
    issue(mk(3'd3, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0));
    issue(mk(3'd4, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0));
    base = ret_data_log.size() + exp_q.size();
    issue(mk(3'd7, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0));
    drain();
    chk("t4_op7_data", ret_data_log[base], 32'd0);
    rf_chk(3'd3, 16'd4, "t4_and");
    rf_chk(3'd4, 16'd7, "t4_or");
    rf_chk(3'd5, 16'd3, "t4_xor");
    rf_chk(3'd6, 16'd0, "t4_op7_rf");
    idle(1);

    // 5: reset with two instructions in flight.
    issue(mk(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 3'd7));
    issue(mk(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 3'd1));
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_res_valid_async", {31'd0, res_valid}, 32'd0);
    chk("t5_in_ready_async", {31'd0, in_ready}, 32'd1);
    chk("t5_res_data_async", res_data, 32'd0);
    chk("t5_alu_a_async", {16'd0, alu_a}, 32'd0);
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_no_result", {31'd0, res_valid}, 32'd0);
    rf_chk_model("t5_rf_zero");

    // 6: random stream with random backpressure and idle gaps.
    rand_rdy = 1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      issue(16'($urandom));
    end
    drain();
    rf_chk_model("t6_final_rf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
